// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and the
// MEM-stage data port. Data has priority; a starvation counter eventually forces a fetch grant.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_valid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_stall_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic                d_valid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_stall_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);
  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              win_d_q, win_d_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      win_d_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      win_d_q     <= win_d_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    win_d_d     = win_d_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    grant_data  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (if_req_i || d_req_i) begin
          grant_data = d_req_i && (!if_req_i || (starve_q < STARVE_MAX));
          win_d_d    = grant_data;
          mem_en_d   = 1'b1;
          state_d    = S_ISSUE;
          if (grant_data) begin
            // Only a contested data win counts against fetch.
            if (if_req_i) starve_d = starve_q + SC_W'(1);
            mem_we_d    = d_we_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
            mem_be_d    = d_be_i;
          end else begin
            starve_d    = '0;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            mem_be_d    = '1;
          end
        end
      end
      S_ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // lat_q == 0 marks the cycle in which mem_rdata is valid.
        if (lat_q == '0) begin
          state_d = S_RESP;
          if (win_d_q) begin
            d_valid_d = 1'b1;
            d_rdata_d = mem_we_q ? '0 : mem_rdata_i;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign if_valid_o  = if_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_stall_o  = if_req_i && !if_valid_q;
  assign d_valid_o   = d_valid_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_stall_o   = d_req_i && !d_valid_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign busy_o      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level timing model checked every cycle
// (LATENCY=2 instance) plus directed literal checks, including a LATENCY=1 instance.
module tb_mem_port_arbiter;
  localparam int L = 2;
  localparam int STARVE = 4;

  logic clk, rst;
  logic if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic if_valid, if_stall, d_valid, d_stall, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic i1_req, d1_req, d1_we;
  logic [31:0] i1_addr, d1_addr, d1_wdata;
  logic [3:0]  d1_be;
  logic i1_valid, i1_stall, d1_valid, d1_stall, m1_en, m1_we, busy1;
  logic [31:0] i1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;

  int nvec = 0, nerr = 0, cyc = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(L), .STARVE_LIMIT(STARVE)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_valid_o(if_valid), .if_rdata_o(if_rdata),
    .if_stall_o(if_stall),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_be_i(d_be),
    .d_valid_o(d_valid), .d_rdata_o(d_rdata), .d_stall_o(d_stall),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_rdata_i(mem_rdata), .busy_o(busy));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .STARVE_LIMIT(STARVE)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req_i(i1_req), .if_addr_i(i1_addr), .if_valid_o(i1_valid), .if_rdata_o(i1_rdata),
    .if_stall_o(i1_stall),
    .d_req_i(d1_req), .d_we_i(d1_we), .d_addr_i(d1_addr), .d_wdata_i(d1_wdata), .d_be_i(d1_be),
    .d_valid_o(d1_valid), .d_rdata_o(d1_rdata), .d_stall_o(d1_stall),
    .mem_en_o(m1_en), .mem_we_o(m1_we), .mem_addr_o(m1_addr), .mem_wdata_o(m1_wdata),
    .mem_be_o(m1_be), .mem_rdata_i(m1_rdata), .busy_o(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a[11:2] == 10'h10) ? 32'h0000_0013 : {16'hC0DE, 4'h0, a[11:2], 2'b00};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memories seen by the DUTs: the read value enters a LATENCY-deep pipe at mem_en.
  bit          wr0 [1024];
  logic [31:0] mw0 [1024];
  logic [31:0] rp0, rp1;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mw0[mem_addr[11:2]] <= merge(wr0[mem_addr[11:2]] ? mw0[mem_addr[11:2]] : init_word(mem_addr),
                                     mem_wdata, mem_be);
        wr0[mem_addr[11:2]] <= 1'b1;
      end
      rp0 <= wr0[mem_addr[11:2]] ? mw0[mem_addr[11:2]] : init_word(mem_addr);
    end
    rp1 <= rp0;
  end
  assign mem_rdata = rp1;

  logic [31:0] rq1;
  always @(posedge clk)
    if (m1_en) rq1 <= init_word(m1_addr);
  assign m1_rdata = rq1;

  // Transaction model: a grant at cycle c gives mem_en at c+1, the pulse at c+2+L
  // and the next arbitration opportunity at c+L+3.
  bit          m_wr [1024];
  logic [31:0] m_mem [1024];
  int          en_c = -1, v_c = -1, free_c = 0, starve = 0;
  bit          v_data;
  logic [31:0] v_val, h_if, h_d, e_addr, e_wdata;
  logic        e_we;
  logic [3:0]  e_be;

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    return m_wr[a[11:2]] ? m_mem[a[11:2]] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      en_c <= -1; v_c <= -1; free_c <= 0; starve <= 0; h_if <= '0; h_d <= '0;
    end else begin
      if (cyc + 1 == v_c) begin
        if (v_data) h_d <= v_val;
        else        h_if <= v_val;
      end
      if (cyc >= free_c && (if_req || d_req)) begin
        en_c <= cyc + 1; v_c <= cyc + 2 + L; free_c <= cyc + L + 3;
        if (d_req && (!if_req || starve < STARVE)) begin
          if (if_req) starve <= starve + 1;
          v_data <= 1'b1; e_addr <= d_addr; e_we <= d_we; e_be <= d_be; e_wdata <= d_wdata;
          if (d_we) begin
            m_mem[d_addr[11:2]] <= merge(m_rd(d_addr), d_wdata, d_be);
            m_wr[d_addr[11:2]]  <= 1'b1;
            v_val <= '0;
          end else v_val <= m_rd(d_addr);
        end else begin
          starve <= 0;
          v_data <= 1'b0; e_addr <= if_addr; e_we <= 1'b0; e_be <= 4'hF;
          v_val <= m_rd(if_addr);
        end
      end
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic e_iv, e_dv;
    e_iv = 1'b0; e_dv = 1'b0;
    if (rst) begin
      chk("rst_mem_en", 64'(mem_en), 64'(0));    chk("rst_mem_we", 64'(mem_we), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0)); chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      chk("rst_mem_be", 64'(mem_be), 64'(0));     chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_if_rdata", 64'(if_rdata), 64'(0)); chk("rst_d_rdata", 64'(d_rdata), 64'(0));
    end else begin
      e_iv = (cyc == v_c) && !v_data;
      e_dv = (cyc == v_c) && v_data;
      chk("mem_en", 64'(mem_en), 64'(cyc == en_c));
      if (cyc == en_c) begin
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        chk("mem_be", 64'(mem_be), 64'(e_be));
        if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      end
      chk("if_rdata", 64'(if_rdata), 64'(h_if));
      chk("d_rdata", 64'(d_rdata), 64'(h_d));
      chk("busy", 64'(busy), 64'(en_c >= 0 && cyc >= en_c && cyc <= v_c));
    end
    chk("if_valid", 64'(if_valid), 64'(e_iv));
    chk("d_valid", 64'(d_valid), 64'(e_dv));
    chk("if_stall", 64'(if_stall), 64'(if_req && !e_iv));
    chk("d_stall", 64'(d_stall), 64'(d_req && !e_dv));
  end

  task automatic to_cyc(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  task automatic neg_at(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  initial begin
    int c0, nev;
    logic [9:0] order;
    rst = 1'b1;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    i1_req = 0; i1_addr = '0; d1_req = 0; d1_we = 0; d1_addr = '0; d1_wdata = '0; d1_be = '0;
    @(negedge clk);
    chk("lit_rst_busy", 64'(busy), 64'(0));
    chk("lit_rst_if_valid", 64'(if_valid), 64'(0));
    to_cyc(3); rst = 1'b0;

    // Single fetch read
    to_cyc(cyc + 1); c0 = cyc; if_req = 1; if_addr = 32'h40;
    neg_at(c0);     chk("lit_f_stall0", 64'(if_stall), 64'(1));
    neg_at(c0 + 1); chk("lit_f_en", 64'(mem_en), 64'(1)); chk("lit_f_addr", 64'(mem_addr), 64'(32'h40));
    neg_at(c0 + 3); chk("lit_f_stall3", 64'(if_stall), 64'(1));
    neg_at(c0 + 4); chk("lit_f_valid", 64'(if_valid), 64'(1));
    chk("lit_f_rdata", 64'(if_rdata), 64'(32'h13)); chk("lit_f_stall4", 64'(if_stall), 64'(0));
    to_cyc(c0 + 5); if_req = 0;

    // Data write, then read back the merged word
    c0 = cyc; d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    neg_at(c0 + 1); chk("lit_w_we", 64'(mem_we), 64'(1)); chk("lit_w_be", 64'(mem_be), 64'(4'b0011));
    neg_at(c0 + 4); chk("lit_w_valid", 64'(d_valid), 64'(1)); chk("lit_w_rdata", 64'(d_rdata), 64'(0));
    to_cyc(c0 + 5); d_we = 0; d_be = 4'hF;
    c0 = cyc;
    neg_at(c0 + 4); chk("lit_r_valid", 64'(d_valid), 64'(1));
    chk("lit_r_rdata", 64'(d_rdata), 64'(32'hC0DEBEEF));
    to_cyc(c0 + 5); d_req = 0;

    // Both requesters held: 4 data grants, then one fetch, repeating
    c0 = cyc; if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h100;
    order = '0; nev = 0;
    for (int k = 0; k < 50; k++) begin
      neg_at(c0 + k);
      if (if_valid || d_valid) begin order = {order[8:0], d_valid}; nev++; end
    end
    chk("lit_grant_order", 64'(order), 64'(10'b1111011110));
    chk("lit_grant_count", 64'(nev), 64'(10));
    to_cyc(c0 + 50); if_req = 0; d_req = 0;

    // Simultaneous single-shot requests
    to_cyc(cyc + 1); c0 = cyc; if_req = 1; d_req = 1;
    neg_at(c0 + 4); chk("lit_s_dvalid", 64'(d_valid), 64'(1)); chk("lit_s_ivalid4", 64'(if_valid), 64'(0));
    to_cyc(c0 + 5); d_req = 0;
    neg_at(c0 + 6); chk("lit_s_en", 64'(mem_en), 64'(1)); chk("lit_s_addr", 64'(mem_addr), 64'(32'h40));
    neg_at(c0 + 9); chk("lit_s_ivalid", 64'(if_valid), 64'(1));
    to_cyc(c0 + 10); if_req = 0;

    // Reset during WAIT of a fetch; request stays up and completes after reset
    to_cyc(cyc + 1); c0 = cyc; if_req = 1;
    to_cyc(c0 + 2); rst = 1;
    neg_at(c0 + 2);
    chk("lit_x_busy", 64'(busy), 64'(0)); chk("lit_x_rdata", 64'(if_rdata), 64'(0));
    chk("lit_x_stall", 64'(if_stall), 64'(1));
    to_cyc(c0 + 4); rst = 0;
    neg_at(c0 + 7); chk("lit_x_novalid", 64'(if_valid), 64'(0));
    neg_at(c0 + 8); chk("lit_x_valid", 64'(if_valid), 64'(1)); chk("lit_x_data", 64'(if_rdata), 64'(32'h13));
    to_cyc(c0 + 9); if_req = 0;

    // LATENCY=1 instance: pulse in cycle 3
    to_cyc(cyc + 1); c0 = cyc; i1_req = 1; i1_addr = 32'h40;
    neg_at(c0 + 1); chk("lit_l1_en", 64'(m1_en), 64'(1));
    neg_at(c0 + 2); chk("lit_l1_novalid", 64'(i1_valid), 64'(0));
    neg_at(c0 + 3); chk("lit_l1_ivalid", 64'(i1_valid), 64'(1));
    chk("lit_l1_irdata", 64'(i1_rdata), 64'(32'h13)); chk("lit_l1_istall", 64'(i1_stall), 64'(0));
    to_cyc(c0 + 4); i1_req = 0;
    c0 = cyc; d1_req = 1; d1_addr = 32'h100; d1_be = 4'hF;
    neg_at(c0 + 3); chk("lit_l1_dvalid", 64'(d1_valid), 64'(1));
    chk("lit_l1_drdata", 64'(d1_rdata), 64'(32'hC0DE0100));
    to_cyc(c0 + 4); d1_req = 0;

    to_cyc(cyc + 3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous unified memory between the pipelined CPU's instruction-fetch stage and its MEM-stage data port. A small FSM issues one access at a time, counts the fixed memory latency and returns the read data to the winner with a one-cycle valid pulse. Data accesses have priority, with a starvation guard for fetch. The arbiter drives stall outputs that hold the pipeline while an access is pending.

## Interface
- ADDR_W, 32, byte address width of both requesters and the memory.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- LATENCY, 2, cycles from the mem_en cycle to the cycle in which mem_rdata is valid; must be ≥1.
- STARVE_LIMIT, 4, consecutive fetch losses tolerated before fetch is forced to win; must be ≥1.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_valid  out  1  one-cycle pulse; if_rdata is valid in that cycle.
- if_rdata  out  DATA_W  fetched word; holds its value until the next fetch response.
- if_stall  out  1  if_req && !if_valid (combinational).
- d_req  in  1  data request; held stable until d_valid.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_be  in  DATA_W/8  byte enables for writes.
- d_valid  out  1  one-cycle pulse; completes a read or acknowledges a write.
- d_rdata  out  DATA_W  read data; forced to 0 on a write response.
- d_stall  out  1  d_req && !d_valid (combinational).
- mem_en, mem_we  out  1  registered; mem_en is high for exactly one cycle per access.
- mem_addr, mem_wdata, mem_be  out  ADDR_W / DATA_W / DATA_W/8  registered; valid while mem_en is high.
- mem_rdata  in  DATA_W  valid LATENCY cycles after the mem_en cycle.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: arbitrates and registers the memory command.
  - ISSUE: mem_en is high.
  - WAIT: counts down LATENCY.
  - RESP: the valid pulse is high; no arbitration takes place in this state.
- IDLE transitions:
  - No request: stay in IDLE.
  - Otherwise, select the winner, load the mem_* registers and go to ISSUE.
- Winner selection:
  - Only one requester active: that requester wins.
  - Both active and starve_cnt < STARVE_LIMIT: data wins, and starve_cnt increments (saturating at STARVE_LIMIT).
  - Both active and starve_cnt == STARVE_LIMIT: fetch wins.
  - Any fetch grant clears starve_cnt to 0.
  - starve_cnt is $clog2(STARVE_LIMIT+1) bits wide.
- Fetch grants drive mem_we = 0 and mem_be = all ones. Data grants pass d_we, d_be and d_wdata through.
- ISSUE → WAIT with lat_cnt = LATENCY-1. If LATENCY = 1, go directly to capture.
- WAIT decrements lat_cnt.
- In the cycle in which mem_rdata is valid, the arbiter captures it into the winner's rdata register and moves to RESP.
- RESP raises the winner's valid for one cycle, then returns to IDLE.
- A request deasserted before its valid pulse is a protocol violation. The access still completes and the pulse is still emitted.

## Timing
- Request sampled in IDLE at cycle 0:
  - mem_en high in cycle 1.
  - mem_rdata sampled in cycle 1+LATENCY.
  - valid pulse in cycle 2+LATENCY (cycle 4 with default parameters).
- Back-to-back throughput is one access per LATENCY+3 cycles: IDLE, ISSUE, LATENCY-1 WAIT cycles, the capture cycle and RESP.
- The valid pulse and the stall drop occur in the same cycle. The pipeline may advance and present a new request in the following cycle, which is IDLE.
- Reset (asynchronous, at any time, including mid-access):
  - FSM returns to IDLE; starve_cnt and lat_cnt clear to 0.
  - mem_en, mem_we, if_valid, d_valid and busy go to 0.
  - mem_addr, mem_wdata, mem_be, if_rdata and d_rdata go to 0.
  - Any in-flight mem_rdata is ignored after reset.
- The stall outputs follow the reset state combinationally: after reset they equal the raw req inputs.

## Test plan
- Reset, then if_req=1 with if_addr=0x40 and memory returning 0x00000013: mem_en=1, mem_addr=0x40 in cycle 1; if_valid=1, if_rdata=0x13 in cycle 4; if_stall=1 in cycles 0-3.
- Data write with d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011: mem_we=1, mem_be=0011 in cycle 1; d_valid in cycle 4 with d_rdata=0.
- if_req and d_req held high continuously: grant order is data ×4, then fetch, then data ×4, and so on; starve_cnt returns to 0 after each fetch grant.
- Simultaneous single-shot requests: data is served first (d_valid in cycle 4); fetch is granted in cycle 5 (IDLE); if_valid arrives in cycle 9.
- Assert rst during WAIT of a read: all outputs are 0 immediately; no valid pulse follows the late mem_rdata; a new if_req after reset completes normally in 4 cycles.
- Repeat the read scenarios with LATENCY=1: the valid pulse arrives in cycle 3.
